// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-code and state definitions for the Datapath2 control unit,
// plus the opcode-to-ALU-operation mapping used by the R/I-type execute steps.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFLO = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_SHR   = 5'd4;
  localparam logic [4:0] ALU_SHL   = 5'd5;
  localparam logic [4:0] ALU_ROR   = 5'd6;
  localparam logic [4:0] ALU_ROL   = 5'd7;
  localparam logic [4:0] ALU_MUL   = 5'd8;
  localparam logic [4:0] ALU_DIV   = 5'd9;
  localparam logic [4:0] ALU_NEG   = 5'd10;
  localparam logic [4:0] ALU_NOT   = 5'd11;
  localparam logic [4:0] ALU_INCPC = 5'd12;

  // T0..T7 are contiguous so a plain increment walks the step sequence.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  function automatic logic [4:0] alu_code(input logic [4:0] op);
    logic [4:0] code;
    case (op)
      OP_ADD, OP_ADDI: code = ALU_ADD;
      OP_SUB:          code = ALU_SUB;
      OP_AND, OP_ANDI: code = ALU_AND;
      OP_OR, OP_ORI:   code = ALU_OR;
      OP_SHR:          code = ALU_SHR;
      OP_SHL:          code = ALU_SHL;
      OP_ROR:          code = ALU_ROR;
      OP_ROL:          code = ALU_ROL;
      OP_MUL:          code = ALU_MUL;
      OP_DIV:          code = ALU_DIV;
      OP_NEG:          code = ALU_NEG;
      OP_NOT:          code = ALU_NOT;
      default:         code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter that stretches a memory step by MEM_WAIT extra cycles;
// o_done is high once the count has run out.
module mem_wait_ctr #(
  parameter int unsigned MEM_WAIT = 32'd0
) (
  input  logic clk,
  input  logic clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  localparam logic [2:0] LP_WAIT = 3'(MEM_WAIT);

  logic [2:0] r_cnt;

  // Reload outside memory steps, count down while a memory step is held.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= 3'd0;
    end else if (i_load) begin
      r_cnt <= LP_WAIT;
    end else if (i_en && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == 3'd0);

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for Datapath2: every strobe is decoded from
// the registered T-step state together with the opcode in ir and con_ff.
module control_unit #(
  parameter int unsigned MEM_WAIT = 32'd0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        BAout,
  output logic        Cout,
  output logic        Rout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        CONin,
  output logic        OutportIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  ALU_Control,
  output logic        run,
  output logic        illegal_op
);

  import cpu_pkg::*;

  state_e     r_state;
  state_e     w_next;
  logic [4:0] w_op;
  logic       w_mem;
  logic       w_done;
  logic       w_last;
  logic       w_halt;
  logic       w_bad;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  mem_wait_ctr #(
    .MEM_WAIT (MEM_WAIT)
  ) u_mem_wait_ctr (
    .clk    (clk),
    .clr    (clr),
    .i_load (~w_mem),
    .i_en   (w_mem),
    .o_done (w_done)
  );

  // State register; clr low drops straight back to idle, abandoning any instruction.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobe decode and next-step selection.
  always_comb begin
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, BAout, Cout, Rout,
     PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, OutportIn,
     Gra, Grb, Grc, Read, Write, run, illegal_op} = 28'd0;
    ALU_Control = 5'd0;
    w_mem       = 1'b0;
    w_last      = 1'b0;
    w_halt      = 1'b0;
    w_bad       = 1'b0;
    w_next      = r_state;

    case (r_state)
      ST_IDLE, ST_HALT: ;
      ST_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_Control = ALU_INCPC;
      end
      ST_T1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = w_done; w_mem = 1'b1;
      end
      ST_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        run = 1'b1;
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (r_state)
              ST_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              ST_T4: begin
                Zin = 1'b1; ALU_Control = alu_code(w_op);
                if (w_op >= OP_ADDI) begin
                  Cout = 1'b1;
                end else begin
                  Grc = 1'b1; Rout = 1'b1;
                end
              end
              default: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
            endcase
          end
          OP_LDI, OP_LD, OP_ST: begin
            case (r_state)
              ST_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              ST_T4: begin Cout = 1'b1; ALU_Control = ALU_ADD; Zin = 1'b1; end
              ST_T5: begin
                Zlowout = 1'b1;
                if (w_op == OP_LDI) begin
                  Gra = 1'b1; Rin = 1'b1; w_last = 1'b1;
                end else begin
                  MARin = 1'b1;
                end
              end
              ST_T6: begin
                if (w_op == OP_ST) begin
                  Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else begin
                  Read = 1'b1; MDRin = w_done; w_mem = 1'b1;
                end
              end
              default: begin
                w_last = 1'b1;
                if (w_op == OP_ST) begin
                  Write = 1'b1; w_mem = 1'b1;
                end else begin
                  MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
              end
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (r_state)
              ST_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              ST_T4: begin Grb = 1'b1; Rout = 1'b1; ALU_Control = alu_code(w_op); Zin = 1'b1; end
              ST_T5: begin Zlowout = 1'b1; LOin = 1'b1; end
              default: begin Zhighout = 1'b1; HIin = 1'b1; w_last = 1'b1; end
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (r_state)
              ST_T3: begin Grb = 1'b1; Rout = 1'b1; ALU_Control = alu_code(w_op); Zin = 1'b1; end
              default: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
            endcase
          end
          OP_BR: begin
            case (r_state)
              ST_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              ST_T4: begin PCout = 1'b1; Yin = 1'b1; end
              ST_T5: begin Cout = 1'b1; ALU_Control = ALU_ADD; Zin = 1'b1; end
              default: begin Zlowout = 1'b1; PCin = con_ff; w_last = 1'b1; end
            endcase
          end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; w_last = 1'b1; end
          OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1; w_last = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
          OP_NOP:  w_last = 1'b1;
          OP_HALT: w_halt = 1'b1;
          default: begin illegal_op = 1'b1; w_last = 1'b1; end
        endcase
      end
      default: w_bad = 1'b1;
    endcase

    if (w_bad) begin
      w_next = ST_IDLE;
    end else if ((r_state == ST_HALT) || w_halt) begin
      w_next = ST_HALT;
    end else if (w_mem && !w_done) begin
      w_next = r_state;
    end else if (w_last) begin
      w_next = stop ? ST_HALT : ST_T0;
    end else begin
      w_next = state_e'(r_state + 4'd1);
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each queued instruction pushes its expected
// per-cycle strobe vectors, which are popped and compared on every falling edge.
module tb_control_unit;
  import cpu_pkg::*;

  localparam int MW = 2;

  localparam logic [32:0] M_PCOUT  = 33'h1 << 0;
  localparam logic [32:0] M_ZHI    = 33'h1 << 1;
  localparam logic [32:0] M_ZLO    = 33'h1 << 2;
  localparam logic [32:0] M_MDROUT = 33'h1 << 3;
  localparam logic [32:0] M_HIOUT  = 33'h1 << 4;
  localparam logic [32:0] M_LOOUT  = 33'h1 << 5;
  localparam logic [32:0] M_INP    = 33'h1 << 6;
  localparam logic [32:0] M_BAOUT  = 33'h1 << 7;
  localparam logic [32:0] M_COUT   = 33'h1 << 8;
  localparam logic [32:0] M_ROUT   = 33'h1 << 9;
  localparam logic [32:0] M_PCIN   = 33'h1 << 10;
  localparam logic [32:0] M_MARIN  = 33'h1 << 11;
  localparam logic [32:0] M_MDRIN  = 33'h1 << 12;
  localparam logic [32:0] M_IRIN   = 33'h1 << 13;
  localparam logic [32:0] M_YIN    = 33'h1 << 14;
  localparam logic [32:0] M_ZIN    = 33'h1 << 15;
  localparam logic [32:0] M_HIIN   = 33'h1 << 16;
  localparam logic [32:0] M_LOIN   = 33'h1 << 17;
  localparam logic [32:0] M_RIN    = 33'h1 << 18;
  localparam logic [32:0] M_CONIN  = 33'h1 << 19;
  localparam logic [32:0] M_OUTIN  = 33'h1 << 20;
  localparam logic [32:0] M_GRA    = 33'h1 << 21;
  localparam logic [32:0] M_GRB    = 33'h1 << 22;
  localparam logic [32:0] M_GRC    = 33'h1 << 23;
  localparam logic [32:0] M_READ   = 33'h1 << 24;
  localparam logic [32:0] M_WRITE  = 33'h1 << 25;
  localparam logic [32:0] M_RUN    = 33'h1 << 26;
  localparam logic [32:0] M_ILL    = 33'h1 << 27;

  typedef struct packed {
    logic [31:0] iw;
    logic        con;
    logic        stp;
  } prog_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, BAout, Cout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, OutportIn;
  logic Gra, Grb, Grc, Read, Write, run, illegal_op;
  logic [4:0]  ALU_Control;
  logic [32:0] w_obs;

  logic [32:0] exp_q[$];
  prog_t       prog_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;

  control_unit #(.MEM_WAIT(MW)) u_dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .BAout(BAout),
    .Cout(Cout), .Rout(Rout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .CONin(CONin), .OutportIn(OutportIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Read(Read), .Write(Write), .ALU_Control(ALU_Control), .run(run),
    .illegal_op(illegal_op)
  );

  assign w_obs = {ALU_Control, illegal_op, run, Write, Read, Grc, Grb, Gra,
                  OutportIn, CONin, Rin, LOin, HIin, Zin, Yin, IRin, MDRin, MARin, PCin,
                  Rout, Cout, BAout, InPortout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

  function automatic logic [32:0] alu_f(input logic [4:0] c);
    return {c, 28'd0};
  endfunction

  function automatic logic [4:0] ref_alu(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_step(input logic [32:0] v);
    if ((v & (M_READ | M_WRITE)) != 33'd0) begin
      for (int k = 0; k < MW; k++) exp_q.push_back(v & ~M_MDRIN);
    end
    exp_q.push_back(v);
  endtask

  task automatic push_instr(input logic [31:0] iw, input logic c, input logic s);
    logic [4:0]  op;
    logic [32:0] r;
    logic [32:0] a;
    op = iw[31:27];
    r  = M_RUN;
    a  = alu_f(ref_alu(op));
    prog_q.push_back({iw, c, s});
    push_step(r | M_PCOUT | M_MARIN | M_ZIN | alu_f(5'd12));
    push_step(r | M_ZLO | M_PCIN | M_READ | M_MDRIN);
    push_step(r | M_MDROUT | M_IRIN);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
        push_step(r | M_GRB | M_ROUT | M_YIN);
        push_step(r | M_GRC | M_ROUT | a | M_ZIN);
        push_step(r | M_ZLO | M_GRA | M_RIN);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        push_step(r | M_GRB | M_ROUT | M_YIN);
        push_step(r | M_COUT | a | M_ZIN);
        push_step(r | M_ZLO | M_GRA | M_RIN);
      end
      OP_LDI, OP_LD, OP_ST: begin
        push_step(r | M_GRB | M_BAOUT | M_YIN);
        push_step(r | M_COUT | alu_f(ALU_ADD) | M_ZIN);
        if (op == OP_LDI) begin
          push_step(r | M_ZLO | M_GRA | M_RIN);
        end else if (op == OP_LD) begin
          push_step(r | M_ZLO | M_MARIN);
          push_step(r | M_READ | M_MDRIN);
          push_step(r | M_MDROUT | M_GRA | M_RIN);
        end else begin
          push_step(r | M_ZLO | M_MARIN);
          push_step(r | M_GRA | M_ROUT | M_MDRIN);
          push_step(r | M_WRITE);
        end
      end
      OP_MUL, OP_DIV: begin
        push_step(r | M_GRA | M_ROUT | M_YIN);
        push_step(r | M_GRB | M_ROUT | a | M_ZIN);
        push_step(r | M_ZLO | M_LOIN);
        push_step(r | M_ZHI | M_HIIN);
      end
      OP_NEG, OP_NOT: begin
        push_step(r | M_GRB | M_ROUT | a | M_ZIN);
        push_step(r | M_ZLO | M_GRA | M_RIN);
      end
      OP_BR: begin
        push_step(r | M_GRA | M_ROUT | M_CONIN);
        push_step(r | M_PCOUT | M_YIN);
        push_step(r | M_COUT | alu_f(ALU_ADD) | M_ZIN);
        push_step(r | M_ZLO | (c ? M_PCIN : 33'd0));
      end
      OP_JR:   push_step(r | M_GRA | M_ROUT | M_PCIN);
      OP_IN:   push_step(r | M_INP | M_GRA | M_RIN);
      OP_OUT:  push_step(r | M_GRA | M_ROUT | M_OUTIN);
      OP_MFHI: push_step(r | M_HIOUT | M_GRA | M_RIN);
      OP_MFLO: push_step(r | M_LOOUT | M_GRA | M_RIN);
      OP_NOP, OP_HALT: push_step(r);
      default: push_step(r | M_ILL);
    endcase
    if (s || (op == OP_HALT)) begin
      for (int k = 0; k < 3; k++) exp_q.push_back(33'd0);
    end
  endtask

  task automatic step();
    logic [32:0] e;
    logic        ld;
    prog_t       p;
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq($sformatf("cyc%0d", cyc), w_obs, e);
    check_eq("bus_excl", 33'($countones(w_obs[9:0]) <= 1), 33'd1);
    ld = w_obs[13];
    cyc++;
    @(posedge clk);
    #1;
    if (ld && (prog_q.size() != 0)) begin
      p      = prog_q.pop_front();
      ir     = p.iw;
      con_ff = p.con;
      stop   = p.stp;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    while ((exp_q.size() != 0) && (budget > 0)) begin
      step();
      budget--;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 33'(exp_q.size()), 33'd0);
  endtask

  task automatic do_reset(input string tag);
    clr    = 1'b0;
    stop   = 1'b0;
    con_ff = 1'b0;
    exp_q.delete();
    prog_q.delete();
    #1;
    check_eq(tag, w_obs, 33'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    exp_q.push_back(33'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; ir = 32'd0; con_ff = 1'b0; stop = 1'b0;
    #2;
    do_reset("reset");

    push_instr(enc(OP_ADD, 4'd1, 4'd2, {4'd3, 15'd0}), 1'b0, 1'b0);
    for (int i = 0; i < 5 + MW; i++) step();
    #2;
    do_reset("clr_abort_t4");

    push_instr(32'hC200_0000, 1'b0, 1'b0);
    push_instr(enc(OP_LD, 4'd1, 4'd2, 19'h45), 1'b0, 1'b0);
    push_instr(enc(OP_BR, 4'd2, 4'd0, 19'd5), 1'b0, 1'b0);
    push_instr(enc(OP_BR, 4'd2, 4'd0, 19'd5), 1'b1, 1'b0);
    push_instr(enc(OP_ST, 4'd3, 4'd0, 19'h20), 1'b0, 1'b0);
    push_instr(enc(OP_ADDI, 4'd5, 4'd6, 19'd7), 1'b0, 1'b0);
    push_instr(enc(OP_AND, 4'd1, 4'd2, {4'd3, 15'd0}), 1'b0, 1'b0);
    push_instr(enc(OP_MUL, 4'd3, 4'd4, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_NEG, 4'd2, 4'd3, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_JR, 4'd6, 4'd0, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_IN, 4'd7, 4'd0, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_OUT, 4'd7, 4'd0, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_MFLO, 4'd8, 4'd0, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_NOP, 4'd0, 4'd0, 19'd0), 1'b0, 1'b0);
    push_instr(enc(5'd20, 4'd1, 4'd1, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_SHL, 4'd1, 4'd2, {4'd3, 15'd0}), 1'b0, 1'b0);
    push_instr(enc(5'd27, 4'd1, 4'd1, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_HALT, 4'd0, 4'd0, 19'd0), 1'b0, 1'b0);
    drain();
    do_reset("halt_exit");

    push_instr(enc(OP_SUB, 4'd1, 4'd2, {4'd3, 15'd0}), 1'b0, 1'b0);
    push_instr(enc(OP_LDI, 4'd4, 4'd0, 19'h12), 1'b0, 1'b0);
    push_instr(enc(OP_DIV, 4'd3, 4'd4, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_NOT, 4'd2, 4'd3, 19'd0), 1'b0, 1'b0);
    push_instr(enc(OP_ORI, 4'd5, 4'd6, 19'h3), 1'b0, 1'b0);
    push_instr(enc(OP_ANDI, 4'd5, 4'd6, 19'hF), 1'b0, 1'b0);
    push_instr(enc(OP_SHR, 4'd1, 4'd2, {4'd3, 15'd0}), 1'b0, 1'b0);
    push_instr(enc(OP_ROR, 4'd1, 4'd2, {4'd3, 15'd0}), 1'b0, 1'b0);
    push_instr(enc(OP_ROL, 4'd1, 4'd2, {4'd3, 15'd0}), 1'b0, 1'b0);
    push_instr(enc(OP_OR, 4'd1, 4'd2, {4'd3, 15'd0}), 1'b0, 1'b1);
    drain();
    do_reset("stop_exit");

    push_instr(enc(OP_HALT, 4'd0, 4'd0, 19'd0), 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
